// File: rtl/ex_arith_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ex_arith_pipe_if : issue/result handshake bundle of ex_arith_pipe     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface ex_arith_pipe_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] reg1_i;
  logic [WIDTH-1:0] reg2_i;
  logic [OP_W-1:0]  alu_op_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] arith_result_o;
  logic             ovf_o;

  modport master (
    output in_valid_i, reg1_i, reg2_i, alu_op_i, out_ready_i,
    input  in_ready_o, out_valid_o, arith_result_o, ovf_o
  );

  modport slave (
    input  in_valid_i, reg1_i, reg2_i, alu_op_i, out_ready_i,
    output in_ready_o, out_valid_o, arith_result_o, ovf_o
  );
endinterface
`default_nettype wire

// File: rtl/ex_arith_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ex_arith_pipe : two-stage ADD/SUB/SLT unit with valid/ready + flush   |
// | Optional macro ARITH_CLZ_EN adds CLZ/CLO.            Rev 1.0          |
// +----------------------------------------------------------------------+
`ifndef EXE_ADD_OP
`define EXE_ADD_OP  8'b00100000
`endif
`ifndef EXE_ADDU_OP
`define EXE_ADDU_OP 8'b00100001
`endif
`ifndef EXE_SUB_OP
`define EXE_SUB_OP  8'b00100010
`endif
`ifndef EXE_SUBU_OP
`define EXE_SUBU_OP 8'b00100011
`endif
`ifndef EXE_SLT_OP
`define EXE_SLT_OP  8'b00101010
`endif
`ifndef EXE_SLTU_OP
`define EXE_SLTU_OP 8'b00101011
`endif
`ifndef EXE_CLZ_OP
`define EXE_CLZ_OP  8'b10110000
`endif
`ifndef EXE_CLO_OP
`define EXE_CLO_OP  8'b10110001
`endif

module ex_arith_pipe #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  ex_arith_pipe_if.slave     bus
);

  localparam logic [OP_W-1:0] c_OP_ADD  = OP_W'(`EXE_ADD_OP);
  localparam logic [OP_W-1:0] c_OP_ADDU = OP_W'(`EXE_ADDU_OP);
  localparam logic [OP_W-1:0] c_OP_SUB  = OP_W'(`EXE_SUB_OP);
  localparam logic [OP_W-1:0] c_OP_SUBU = OP_W'(`EXE_SUBU_OP);
  localparam logic [OP_W-1:0] c_OP_SLT  = OP_W'(`EXE_SLT_OP);
  localparam logic [OP_W-1:0] c_OP_SLTU = OP_W'(`EXE_SLTU_OP);
`ifdef ARITH_CLZ_EN
  localparam logic [OP_W-1:0] c_OP_CLZ  = OP_W'(`EXE_CLZ_OP);
  localparam logic [OP_W-1:0] c_OP_CLO  = OP_W'(`EXE_CLO_OP);
`endif
  localparam int c_MSB = WIDTH - 1;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [OP_W-1:0]  r_s1_op;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_result;
  logic             r_s2_ovf;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_diff_ext;
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [WIDTH-1:0] w_result;
  logic             w_ovf;

  assign w_s2_adv = !r_s2_valid || bus.out_ready_i;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;

  assign bus.in_ready_o     = w_s1_adv && !flush_i;
  assign bus.out_valid_o    = r_s2_valid;
  assign bus.arith_result_o = r_s2_result;
  assign bus.ovf_o          = r_s2_ovf;

  // Subtraction as A + ~B + 1; the carry out is the inverted unsigned borrow.
  assign w_sum      = r_s1_a + r_s1_b;
  assign w_diff_ext = {1'b0, r_s1_a} + {1'b0, ~r_s1_b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_diff     = w_diff_ext[WIDTH-1:0];
  assign w_borrow   = !w_diff_ext[WIDTH];

  assign w_add_ovf = (r_s1_a[c_MSB] == r_s1_b[c_MSB]) && (w_sum[c_MSB]  != r_s1_a[c_MSB]);
  assign w_sub_ovf = (r_s1_a[c_MSB] != r_s1_b[c_MSB]) && (w_diff[c_MSB] != r_s1_a[c_MSB]);

`ifdef ARITH_CLZ_EN
  function automatic logic [WIDTH-1:0] f_lead_zeros(input logic [WIDTH-1:0] v);
    logic             done;
    logic [WIDTH-1:0] cnt;
    cnt  = '0;
    done = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!done) begin
        if (v[i]) done = 1'b1;
        else      cnt  = cnt + WIDTH'(1);
      end
    end
    return cnt;
  endfunction
`endif

  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    case (r_s1_op)
      c_OP_ADD:  begin w_result = w_sum;  w_ovf = w_add_ovf; end
      c_OP_ADDU: w_result = w_sum;
      c_OP_SUB:  begin w_result = w_diff; w_ovf = w_sub_ovf; end
      c_OP_SUBU: w_result = w_diff;
      // Sign of the true difference: result MSB corrected by overflow.
      c_OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_diff[c_MSB] ^ w_sub_ovf};
      c_OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, w_borrow};
`ifdef ARITH_CLZ_EN
      c_OP_CLZ:  w_result = f_lead_zeros(r_s1_a);
      c_OP_CLO:  w_result = f_lead_zeros(~r_s1_a);
`endif
      default:   begin end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_op     <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_ovf    <= 1'b0;
    end else if (flush_i) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_result <= w_result;
          r_s2_ovf    <= w_ovf;
        end
      end
      if (w_s1_adv) begin
        r_s1_valid <= bus.in_valid_i;
        if (bus.in_valid_i) begin
          r_s1_a  <= bus.reg1_i;
          r_s1_b  <= bus.reg2_i;
          r_s1_op <= bus.alu_op_i;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_arith_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ex_arith_pipe : directed + random bench with a queue-based model   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`ifndef EXE_ADD_OP
`define EXE_ADD_OP  8'b00100000
`endif
`ifndef EXE_ADDU_OP
`define EXE_ADDU_OP 8'b00100001
`endif
`ifndef EXE_SUB_OP
`define EXE_SUB_OP  8'b00100010
`endif
`ifndef EXE_SUBU_OP
`define EXE_SUBU_OP 8'b00100011
`endif
`ifndef EXE_SLT_OP
`define EXE_SLT_OP  8'b00101010
`endif
`ifndef EXE_SLTU_OP
`define EXE_SLTU_OP 8'b00101011
`endif
`ifndef EXE_CLZ_OP
`define EXE_CLZ_OP  8'b10110000
`endif
`ifndef EXE_CLO_OP
`define EXE_CLO_OP  8'b10110001
`endif

module tb_ex_arith_pipe;
  localparam int WIDTH = 32;
  localparam int OP_W  = 8;
  localparam logic [7:0] OP_ADD  = `EXE_ADD_OP;
  localparam logic [7:0] OP_ADDU = `EXE_ADDU_OP;
  localparam logic [7:0] OP_SUB  = `EXE_SUB_OP;
  localparam logic [7:0] OP_SUBU = `EXE_SUBU_OP;
  localparam logic [7:0] OP_SLT  = `EXE_SLT_OP;
  localparam logic [7:0] OP_SLTU = `EXE_SLTU_OP;
  localparam logic [7:0] OP_CLZ  = `EXE_CLZ_OP;
  localparam logic [7:0] OP_CLO  = `EXE_CLO_OP;
  localparam logic [7:0] OP_BAD  = 8'hFF;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;

  ex_arith_pipe_if #(.WIDTH(WIDTH), .OP_W(OP_W)) bus ();

  ex_arith_pipe #(.WIDTH(WIDTH), .OP_W(OP_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // In-flight ops in issue order; cap is the edge count at which each was taken.
  typedef struct packed {
    int unsigned cap;
    logic        ovf;
    logic [31:0] res;
  } item_t;

  item_t       q[$];
  int unsigned cyc      = 0;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [31:0] lead_count(input logic [31:0] a, input logic bitval);
    logic [31:0] n;
    n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (a[i] != bitval) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic [32:0] ref_op(input logic [7:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, s;
    logic [31:0] r;
    logic v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    r  = '0;
    v  = 1'b0;
    case (op)
      OP_ADD:  begin s = sa + sb; r = a + b; v = (s > MAXS) || (s < MINS); end
      OP_ADDU: r = a + b;
      OP_SUB:  begin s = sa - sb; r = a - b; v = (s > MAXS) || (s < MINS); end
      OP_SUBU: r = a - b;
      OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
`ifdef ARITH_CLZ_EN
      OP_CLZ:  r = lead_count(a, 1'b0);
      OP_CLO:  r = lead_count(a, 1'b1);
`endif
      default: ;
    endcase
    return {v, r};
  endfunction

  function automatic logic exp_valid();
    return (q.size() > 0) && ((cyc - q[0].cap) >= 1);
  endfunction

  function automatic logic exp_ready();
    return !flush && ((q.size() < 2) || bus.out_ready_i);
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    logic ev;
    ev = exp_valid();
    chk("out_valid", {63'd0, bus.out_valid_o}, {63'd0, ev});
    if (ev) begin
      chk("result", {32'd0, bus.arith_result_o}, {32'd0, q[0].res});
      chk("ovf", {63'd0, bus.ovf_o}, {63'd0, q[0].ovf});
    end
  endtask

  // Inputs are already applied; advance one clock and update the model.
  task automatic step();
    logic  er, in_fire, out_fire;
    logic [32:0] ro;
    item_t it;
    #1;
    er = exp_ready();
    chk("in_ready", {63'd0, bus.in_ready_o}, {63'd0, er});
    in_fire  = bus.in_valid_i && er;
    out_fire = exp_valid() && bus.out_ready_i;
    ro = ref_op(bus.alu_op_i, bus.reg1_i, bus.reg2_i);
    @(posedge clk);
    cyc++;
    if (out_fire) void'(q.pop_front());
    if (flush) q.delete();
    else if (in_fire) begin
      it.cap = cyc;
      it.ovf = ro[32];
      it.res = ro[31:0];
      q.push_back(it);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic ordy, input logic fl);
    bus.in_valid_i  = v;
    bus.alu_op_i    = op;
    bus.reg1_i      = a;
    bus.reg2_i      = b;
    bus.out_ready_i = ordy;
    flush           = fl;
    step();
  endtask

  task automatic expect_out(input string tag, input logic [31:0] res, input logic ovf);
    chk({tag, "_valid"}, {63'd0, bus.out_valid_o}, 64'd1);
    chk({tag, "_res"}, {32'd0, bus.arith_result_o}, {32'd0, res});
    chk({tag, "_ovf"}, {63'd0, bus.ovf_o}, {63'd0, ovf});
  endtask

  // Single op with the consumer always ready; result checked two edges after issue.
  task automatic single(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic ovf);
    drive(1'b1, op, a, b, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 32'd0, 32'd0, 1'b1, 1'b0);
    expect_out(tag, res, ovf);
    drive(1'b0, 8'h00, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops [9];
    ops = '{OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_SLT, OP_SLTU, OP_CLZ, OP_CLO, OP_BAD};

    bus.in_valid_i  = 1'b0;
    bus.alu_op_i    = 8'h00;
    bus.reg1_i      = 32'd0;
    bus.reg2_i      = 32'd0;
    bus.out_ready_i = 1'b1;
    rst             = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {63'd0, bus.out_valid_o}, 64'd0);
    chk("rst_res", {32'd0, bus.arith_result_o}, 64'd0);
    chk("rst_ovf", {63'd0, bus.ovf_o}, 64'd0);
    rst = 1'b1;
    drive(1'b0, 8'h00, 32'd0, 32'd0, 1'b1, 1'b0);

    single("add_ovf",  OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
    single("addu",     OP_ADDU, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0);
    single("sub_ovf",  OP_SUB,  32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1);
    single("subu",     OP_SUBU, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0);
    single("slt_neg",  OP_SLT,  32'h8000_0000, 32'h0000_0001, 32'd1,         1'b0);
    single("sltu",     OP_SLTU, 32'h8000_0000, 32'h0000_0001, 32'd0,         1'b0);
    single("slt_ovf",  OP_SLT,  32'h7FFF_FFFF, 32'h8000_0000, 32'd0,         1'b0);
    single("bad_op",   OP_BAD,  32'h1234_5678, 32'h1111_1111, 32'd0,         1'b0);
`ifdef ARITH_CLZ_EN
    single("clz",      OP_CLZ,  32'h0001_0000, 32'd0,         32'd15,        1'b0);
    single("clo",      OP_CLO,  32'hFFFF_FFFF, 32'd0,         32'd32,        1'b0);
`else
    single("clz_off",  OP_CLZ,  32'h0001_0000, 32'd0,         32'd0,         1'b0);
`endif

    // Back-pressure: two ops fill the pipe, the third waits.
    drive(1'b1, OP_ADDU, 32'd1, 32'd1, 1'b0, 1'b0);
    drive(1'b1, OP_ADDU, 32'd2, 32'd2, 1'b0, 1'b0);
    bus.reg1_i = 32'd3;
    bus.reg2_i = 32'd3;
    #1 chk("bp_in_ready", {63'd0, bus.in_ready_o}, 64'd0);
    step();
    drive(1'b1, OP_ADDU, 32'd3, 32'd3, 1'b0, 1'b0);
    expect_out("bp_hold", 32'd2, 1'b0);
    drive(1'b1, OP_ADDU, 32'd3, 32'd3, 1'b1, 1'b0);
    expect_out("bp_second", 32'd4, 1'b0);
    drive(1'b0, 8'h00, 32'd0, 32'd0, 1'b1, 1'b0);
    expect_out("bp_third", 32'd6, 1'b0);
    drive(1'b0, 8'h00, 32'd0, 32'd0, 1'b1, 1'b0);

    // Flush with two ops in flight, then a clean op.
    drive(1'b1, OP_ADD, 32'd1, 32'd2, 1'b0, 1'b0);
    drive(1'b1, OP_ADD, 32'd3, 32'd4, 1'b0, 1'b0);
    flush           = 1'b1;
    bus.out_ready_i = 1'b1;
    #1 chk("flush_in_ready", {63'd0, bus.in_ready_o}, 64'd0);
    step();
    chk("flush_out_valid", {63'd0, bus.out_valid_o}, 64'd0);
    single("post_flush", OP_SUB, 32'd10, 32'd3, 32'd7, 1'b0);

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, ops[$urandom_range(0, 8)], rnd_word(), rnd_word(),
            $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3);
    end
    drive(1'b0, 8'h00, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 32'd0, 32'd0, 1'b1, 1'b0);

    // Asynchronous reset with the pipe full and stalled.
    drive(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    drive(1'b1, OP_SUB, 32'd9, 32'd4, 1'b0, 1'b0);
    bus.in_valid_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", {63'd0, bus.out_valid_o}, 64'd0);
    chk("arst_res", {32'd0, bus.arith_result_o}, 64'd0);
    chk("arst_ovf", {63'd0, bus.ovf_o}, 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 8'h00, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 32'd0, 32'd0, 1'b1, 1'b0);
    single("post_rst", OP_ADDU, 32'd40, 32'd2, 32'd42, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
